gameport_timer: RTL and testbench
=================================

GAMEPORT_TIMER -- requirements
Module: gameport_timer

Interface
REQ-001 SHALL have port CLK_14M, input, 1: 14.31818 MHz master clock; the only clock.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high.
REQ-003 SHALL have port CLK_2M, input, 1: core 2 MHz clock, sampled as data; each rising edge seen at CLK_14M is one "tick".
REQ-004 SHALL have port PDL_STROBE, input, 1: pulses high (≥1 CLK_14M cycle) when the core reads C07x.
REQ-005 SHALL have port joy_an, input, 32: four signed 8-bit axes, paddle n at bits [8n+7:8n].
REQ-006 SHALL have port pdl, output, 4: one-shot outputs feeding GAMEPORT bits 7..4, pdl[n] = paddle n.
REQ-007 SHALL have port busy, output, 1: OR of all channel RUN states.

Function
REQ-008 SHALL detect a tick when registered CLK_2M is 0 and current CLK_2M is 1; all channel activity happens only on ticks.
REQ-009 SHALL latch any PDL_STROBE high cycle into a pending flag, consumed and cleared at the next tick.
REQ-010 SHALL clear pending on a tick even if PDL_STROBE is high that same cycle, then set it again.
REQ-011 SHALL compute per channel, on a tick with pending set, load = 2800 + 22*signed(axis) as a signed value of at least 16 bits.
REQ-012 SHALL clamp load: below 0 -> 0; 5590 or above -> 5650; otherwise unchanged. Axis 0 -> 2800, axis 0x7F -> 5650, axis 0x80 -> 0.
REQ-013 SHALL give each channel two states: IDLE and RUN.
REQ-014 On a load tick, SHALL store load in the channel's 13-bit counter; the channel enters RUN if load > 0 and IDLE if load = 0.
REQ-015 On a non-load tick in RUN with counter > 0, SHALL decrement the counter; at counter = 0 the channel SHALL go IDLE.
REQ-016 SHALL drive pdl[n] registered: high on every tick where the counter was > 0 before that tick's update, low otherwise.
REQ-017 Consequence of REQ-016: the first high tick is the one after the load tick, and pdl[n] stays high for exactly load ticks.
REQ-018 SHALL make a load tick during RUN retrigger the channel: the counter is overwritten with the new load, with no low gap.
REQ-019 SHALL sample the axis values only on the load tick; axis changes during RUN SHALL not affect the count.
REQ-020 SHALL process all channels in parallel from the same tick and pending flag.

Reset
REQ-021 While reset is high, SHALL force all counters to 0, all channels to IDLE, pending to 0, pdl to 4'b0000, busy to 0 and the CLK_2M edge register to 0.
REQ-022 Reset asserted mid-RUN SHALL abort immediately: pdl low on the next CLK_14M edge.
REQ-023 A strobe coincident with reset SHALL be discarded.

Configuration
REQ-024 With macro GAMEPORT_PDL23_EN defined, SHALL implement all four channels.
REQ-025 Without GAMEPORT_PDL23_EN, SHALL implement channels 0–1 only: pdl[3:2] tied 0, joy_an[31:16] ignored, no logic for channels 2–3.

Structure
REQ-026 SHALL take constants PDL_CENTER=2800, PDL_SCALE=22, PDL_CLAMP=5590, PDL_MAX=5650 and the channel state enum from shared package apple2_pkg.
REQ-027 SHALL instantiate one sub-module pdl_channel per paddle; tick detection and the pending flag stay in the top level.

Verification
REQ-028 Axis0=0x00, strobe, then 6000 ticks -> pdl[0] high exactly 2800 ticks, starting the tick after the load tick.
REQ-029 Axis1=0x7F -> 5650 ticks high; axis1=0x80 -> pdl[1] never rises and busy stays 0 for that channel.
REQ-030 Axis0=0x00, strobe, second strobe at tick 1000 with axis0=0x10 -> high continuously for 1000+3152 ticks total.
REQ-031 Reset asserted at tick 500 of a 2800-tick run -> pdl=0 and busy=0 on the next CLK_14M edge; no pulse resumes after reset release.
REQ-032 1-cycle PDL_STROBE placed mid-CLK_2M-high -> load occurs at the next tick; axis changed after the load tick -> duration unchanged.
REQ-033 Build without GAMEPORT_PDL23_EN, axes 2/3=0x00, strobe -> pdl[3:2] stay 0 while pdl[1:0] pulse 2800 ticks.

Source files
------------

// File: rtl/apple2_pkg.sv
// Shared Apple II definitions for the paddle (game port) timers:
// one-shot timing constants, channel state encoding and the
// axis-to-count conversion used by every paddle channel.
package apple2_pkg;

  // One-shot length in CLK_2M ticks for a centred axis, per axis step,
  // the raw value at which the count saturates, and the saturated count.
  localparam int PDL_CENTER = 2800;
  localparam int PDL_SCALE  = 22;
  localparam int PDL_CLAMP  = 5590;
  localparam int PDL_MAX    = 5650;

  // Counter width: PDL_MAX fits in 13 bits.
  localparam int PDL_CNT_W  = 13;

  typedef enum logic {
    PDL_IDLE = 1'b0,
    PDL_RUN  = 1'b1
  } pdl_state_t;

  // Convert a signed 8-bit axis into a clamped one-shot length.
  function automatic logic [PDL_CNT_W-1:0] pdl_load_value(input logic [7:0] axis);
    logic signed [15:0] axis_s;
    logic signed [15:0] raw;
    logic [PDL_CNT_W-1:0] result;
    axis_s = {{8{axis[7]}}, axis};
    raw    = 16'(PDL_CENTER) + 16'(PDL_SCALE) * axis_s;
    if (raw < 16'sd0) begin
      result = '0;
    end else if (raw >= 16'(PDL_CLAMP)) begin
      result = PDL_CNT_W'(PDL_MAX);
    end else begin
      result = raw[PDL_CNT_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/pdl_channel.sv
// One paddle one-shot: loads a count from its axis on a load tick,
// counts down one per tick and drives its registered pdl output high
// while the count before each tick's update is non-zero.
module pdl_channel
  import apple2_pkg::*;
(
  input  logic       CLK_14M,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] axis,
  output logic       pdl,
  output logic       run
);

  pdl_state_t           state;
  logic [PDL_CNT_W-1:0] count;
  logic [PDL_CNT_W-1:0] load_value;

  // Axis is only consumed on a load tick, so later changes do not matter.
  always_comb begin
    load_value = pdl_load_value(axis);
  end

  // Channel FSM, down-counter and registered one-shot output.
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      state <= PDL_IDLE;
      count <= '0;
      pdl   <= 1'b0;
    end else if (tick) begin
      // Output reflects the count before this tick's update, so a
      // retrigger during RUN leaves no low gap.
      pdl <= (count != '0);
      if (load) begin
        count <= load_value;
        state <= (load_value != '0) ? PDL_RUN : PDL_IDLE;
      end else begin
        case (state)
          PDL_RUN: begin
            if (count != '0) begin
              count <= count - 1'b1;
            end else begin
              state <= PDL_IDLE;
            end
          end
          default: state <= PDL_IDLE;
        endcase
      end
    end
  end

  assign run = (state == PDL_RUN);

endmodule

// File: rtl/gameport_timer.sv
// Apple II game port paddle timers. Detects CLK_2M rising edges (ticks)
// in the CLK_14M domain, latches C07x strobes until the next tick and
// fans the resulting load tick out to one pdl_channel per paddle.
// Channels 2-3 are only built when GAMEPORT_PDL23_EN is defined.
module gameport_timer
  import apple2_pkg::*;
(
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic        CLK_2M,
  input  logic        PDL_STROBE,
  input  logic [31:0] joy_an,
  output logic [3:0]  pdl,
  output logic        busy
);

`ifdef GAMEPORT_PDL23_EN
  localparam int NUM_CH = 4;
`else
  localparam int NUM_CH = 2;

  // Upper axes have no consumer in the two-channel build.
  logic unused_axes;
  assign unused_axes = ^joy_an[31:16];
  assign pdl[3:2]    = '0;
`endif

  logic              clk2m_q;
  logic              pending;
  logic              tick;
  logic              load_tick;
  logic [NUM_CH-1:0] run;

  // CLK_2M is sampled as data; remember the previous sample for edge detect.
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      clk2m_q <= 1'b0;
    end else begin
      clk2m_q <= CLK_2M;
    end
  end

  assign tick      = CLK_2M & ~clk2m_q;
  assign load_tick = tick & pending;

  // Strobe latch: consumed on a tick, re-armed by a strobe in that same cycle.
  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= PDL_STROBE;
    end else if (PDL_STROBE) begin
      pending <= 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pdl_channel u_ch (
      .CLK_14M (CLK_14M),
      .reset   (reset),
      .tick    (tick),
      .load    (load_tick),
      .axis    (joy_an[8*n +: 8]),
      .pdl     (pdl[n]),
      .run     (run[n])
    );
  end

  assign busy = |run;

endmodule

// File: tb/tb_gameport_timer.sv
// Self-checking bench for gameport_timer: a timestamp-based reference
// model checked every cycle, a table of axis/length pairs, and directed
// retrigger, reset-abort and strobe-timing sequences.
module tb_gameport_timer;

`ifdef GAMEPORT_PDL23_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif

  logic        CLK_14M = 1'b0;
  logic        reset;
  logic        CLK_2M;
  logic        PDL_STROBE;
  logic [31:0] joy_an;
  logic [3:0]  pdl;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;
  int hi_cnt[4];

  gameport_timer dut (
    .CLK_14M    (CLK_14M),
    .reset      (reset),
    .CLK_2M     (CLK_2M),
    .PDL_STROBE (PDL_STROBE),
    .joy_an     (joy_an),
    .pdl        (pdl),
    .busy       (busy)
  );

  always #5 CLK_14M = ~CLK_14M;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ref_len(input logic [7:0] a);
    int v;
    v = 2800 + 22 * int'($signed(a));
    if (v < 0) return 0;
    if (v >= 5590) return 5650;
    return v;
  endfunction

  // Reference model: each channel is described by the tick index of its
  // latest load and that load's length. Output after tick t is high when
  // t lies in (load_tick, load_tick+len] of the load in force before t.
  int         m_tick = 0;
  int         m_lt[4];
  int         m_len[4];
  bit         m_prev, m_pend;
  logic [3:0] exp_pdl  = '0;
  logic       exp_busy = 1'b0;

  always @(posedge CLK_14M) begin
    if (reset) begin
      m_prev = 0;
      m_pend = 0;
      for (int n = 0; n < 4; n++) begin
        m_lt[n]  = -1000000;
        m_len[n] = 0;
      end
      exp_pdl  = '0;
      exp_busy = 1'b0;
    end else begin
      if (!m_prev && CLK_2M) begin
        m_tick++;
        for (int n = 0; n < NCH; n++)
          exp_pdl[n] = (m_tick > m_lt[n]) && (m_tick <= m_lt[n] + m_len[n]);
        if (m_pend) begin
          for (int n = 0; n < NCH; n++) begin
            m_lt[n]  = m_tick;
            m_len[n] = ref_len(joy_an[8*n +: 8]);
          end
        end
        m_pend   = PDL_STROBE;
        exp_busy = 1'b0;
        for (int n = 0; n < NCH; n++)
          if (m_len[n] > 0 && m_tick >= m_lt[n] && m_tick <= m_lt[n] + m_len[n])
            exp_busy = 1'b1;
      end else if (PDL_STROBE) begin
        m_pend = 1;
      end
      m_prev = CLK_2M;
    end
  end

  always @(negedge CLK_14M) begin
    if (chk_en) begin
      chk("pdl_model", int'(pdl), int'(exp_pdl));
      chk("busy_model", int'(busy), int'(exp_busy));
    end
  end

  task automatic cyc();
    @(posedge CLK_14M);
    #1;
  endtask

  // One CLK_2M period: lo cycles low then hi cycles high. The edge after
  // cycle index lo is the tick. strb_at selects the one cycle whose edge
  // sees PDL_STROBE high (-1 for none).
  task automatic tick_period(input int lo, input int hi, input int strb_at);
    for (int i = 0; i < lo + hi; i++) begin
      CLK_2M     = (i >= lo);
      PDL_STROBE = (i == strb_at);
      cyc();
      if (i == lo)
        for (int n = 0; n < 4; n++) if (pdl[n]) hi_cnt[n]++;
    end
    PDL_STROBE = 1'b0;
  endtask

  task automatic clr_cnt();
    for (int n = 0; n < 4; n++) hi_cnt[n] = 0;
  endtask

  task automatic run_ticks(input int k);
    for (int i = 0; i < k; i++) tick_period(1, 1, -1);
  endtask

  typedef struct {
    logic [7:0] a0;
    logic [7:0] a1;
    int         e0;
    int         e1;
  } vec_t;

  vec_t tbl[4];
  int   e23;
  int   lo, hi, sa;

  initial begin
    tbl[0] = '{a0: 8'h00, a1: 8'h7F, e0: 2800, e1: 5650};
    tbl[1] = '{a0: 8'h7E, a1: 8'h80, e0: 5572, e1: 0};
    tbl[2] = '{a0: 8'h81, a1: 8'h82, e0: 6,    e1: 28};
    tbl[3] = '{a0: 8'h90, a1: 8'hFF, e0: 336,  e1: 2778};
`ifdef GAMEPORT_PDL23_EN
    e23 = 2800;
`else
    e23 = 0;
`endif

    reset = 1'b1; CLK_2M = 1'b0; PDL_STROBE = 1'b0; joy_an = '0;
    cyc(); cyc();
    chk("reset_pdl", int'(pdl), 0);
    chk("reset_busy", int'(busy), 0);
    chk_en = 1;
    reset  = 1'b0;
    run_ticks(3);

    // Table: two channels loaded per entry, axes 2/3 held at 0x00.
    foreach (tbl[k]) begin
      joy_an = {8'h00, 8'h00, tbl[k].a1, tbl[k].a0};
      clr_cnt();
      tick_period(1, 1, 0);
      if (tbl[k].e1 == 0) chk("zero_load_busy_ch1", int'(busy), int'(tbl[k].e0 > 0));
      run_ticks(((tbl[k].e0 > tbl[k].e1) ? tbl[k].e0 : tbl[k].e1) + 5);
      chk($sformatf("len_ch0_%0d", k), hi_cnt[0], tbl[k].e0);
      chk($sformatf("len_ch1_%0d", k), hi_cnt[1], tbl[k].e1);
      if (k == 0) begin
        chk("len_ch2", hi_cnt[2], e23);
        chk("len_ch3", hi_cnt[3], e23);
      end
      chk($sformatf("idle_busy_%0d", k), int'(busy), 0);
    end

    // Retrigger at tick 1000 with axis0 = 0x10.
    joy_an = '0;
    clr_cnt();
    tick_period(1, 1, 0);
    run_ticks(999);
    joy_an[7:0] = 8'h10;
    tick_period(1, 1, 0);
    run_ticks(3200);
    chk("retrigger_ch0", hi_cnt[0], 1000 + 3152);
    chk("retrigger_ch1", hi_cnt[1], 1000 + 2800);

    // Reset at tick 500, with a strobe coincident with reset.
    joy_an = '0;
    tick_period(1, 1, 0);
    run_ticks(500);
    reset = 1'b1; PDL_STROBE = 1'b1;
    cyc();
    chk("reset_abort_pdl", int'(pdl), 0);
    chk("reset_abort_busy", int'(busy), 0);
    reset = 1'b0; PDL_STROBE = 1'b0;
    clr_cnt();
    run_ticks(3000);
    chk("no_resume_ch0", hi_cnt[0], 0);
    chk("no_resume_busy", int'(busy), 0);

    // Strobe mid-high phase; axis changed after the load tick.
    joy_an = '0;
    clr_cnt();
    tick_period(1, 4, 3);
    chk("mid_high_no_load", int'(busy), 0);
    tick_period(1, 1, -1);
    chk("mid_high_loaded", int'(busy), 1);
    joy_an = {4{8'h7F}};
    run_ticks(2810);
    chk("axis_change_len", hi_cnt[0], 2800);

    // Randomized CLK_2M phases, strobe placement and axes.
    for (int i = 0; i < 400; i++) begin
      lo = int'($urandom_range(1, 3));
      hi = int'($urandom_range(1, 4));
      sa = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, lo + hi - 1)) : -1;
      if ($urandom_range(0, 3) == 0) joy_an = $urandom;
      tick_period(lo, hi, sa);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
